decode_execute_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage RISC-V core; captures decode-stage operands, addresses and control each cycle and presents them to the execute stage.
- Its rs1_e/rs2_e outputs feed the execute forwarding muxes; its rs1_addr_e/rs2_addr_e/rd_addr_e feed the hazard unit.
- Contains built-in load-use detection and automatic bubble insertion, so the hazard unit only has to apply the returned stall to the fetch and decode stages.

---
 rtl/decode_execute_reg_pkg.sv | 28 ++
 rtl/decode_execute_reg_if.sv | 54 +++++
 rtl/decode_execute_reg_load_use_detect.sv | 24 ++
 rtl/decode_execute_reg.sv | 105 ++++++++++
 tb/tb_decode_execute_reg.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/decode_execute_reg_pkg.sv
// Shared core definitions for the ID/EX pipeline register.
// Holds the result-source encodings, the ALU control encodings and the
// packed control bundle that travels from decode into execute.
package decode_execute_reg_pkg;

    // Result source select
    localparam logic [1:0] RESULT_ALU  = 2'b00;
    localparam logic [1:0] RESULT_LOAD = 2'b01;
    localparam logic [1:0] RESULT_PC4  = 2'b10;

    // ALU operation encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic [2:0] alu_ctrl;
        logic       alu_src;
        logic       branch;
        logic       jump;
    } ctrl_t;

endpackage

// File: rtl/decode_execute_reg_if.sv
// Decode-to-execute bundle.
//   *_d      : decode-stage operands, addresses and control
//   *_e      : registered copies presented to execute
//   flush_e  : kill the instruction entering execute
//   stall_e  : hold execute contents
//   lw_stall : load-use hazard back to the hazard unit
// master = decode/hazard side, slave = the pipeline register.
interface decode_execute_reg_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
);
    logic            valid_d,      valid_e;
    logic [XLEN-1:0] rs1_data_d,   rs1_data_e;
    logic [XLEN-1:0] rs2_data_d,   rs2_data_e;
    logic [XLEN-1:0] imm_d,        imm_e;
    logic [XLEN-1:0] pc_d,         pc_e;
    logic [XLEN-1:0] pc_plus4_d,   pc_plus4_e;
    logic [RA_W-1:0] rs1_addr_d,   rs1_addr_e;
    logic [RA_W-1:0] rs2_addr_d,   rs2_addr_e;
    logic [RA_W-1:0] rd_addr_d,    rd_addr_e;
    logic            reg_write_d,  reg_write_e;
    logic            mem_write_d,  mem_write_e;
    logic [1:0]      result_src_d, result_src_e;
    logic [2:0]      alu_ctrl_d,   alu_ctrl_e;
    logic            alu_src_d,    alu_src_e;
    logic            branch_d,     branch_e;
    logic            jump_d,       jump_e;
    logic            flush_e;
    logic            stall_e;
    logic            lw_stall;

    modport master (
        output valid_d, rs1_data_d, rs2_data_d, imm_d, pc_d, pc_plus4_d,
               rs1_addr_d, rs2_addr_d, rd_addr_d, reg_write_d, mem_write_d,
               result_src_d, alu_ctrl_d, alu_src_d, branch_d, jump_d,
               flush_e, stall_e,
        input  valid_e, rs1_data_e, rs2_data_e, imm_e, pc_e, pc_plus4_e,
               rs1_addr_e, rs2_addr_e, rd_addr_e, reg_write_e, mem_write_e,
               result_src_e, alu_ctrl_e, alu_src_e, branch_e, jump_e,
               lw_stall
    );

    modport slave (
        input  valid_d, rs1_data_d, rs2_data_d, imm_d, pc_d, pc_plus4_d,
               rs1_addr_d, rs2_addr_d, rd_addr_d, reg_write_d, mem_write_d,
               result_src_d, alu_ctrl_d, alu_src_d, branch_d, jump_d,
               flush_e, stall_e,
        output valid_e, rs1_data_e, rs2_data_e, imm_e, pc_e, pc_plus4_e,
               rs1_addr_e, rs2_addr_e, rd_addr_e, reg_write_e, mem_write_e,
               result_src_e, alu_ctrl_e, alu_src_e, branch_e, jump_e,
               lw_stall
    );

endinterface

// File: rtl/decode_execute_reg_load_use_detect.sv
// Combinational load-use hazard detector.
//   valid_e, result_src_e, rd_addr_e : instruction currently in execute
//   valid_d, rs1_addr_d, rs2_addr_d  : instruction currently in decode
//   lw_stall                         : decode reads a load's destination
module decode_execute_reg_load_use_detect
    import decode_execute_reg_pkg::*;
#(
    parameter int unsigned RA_W = 5
) (
    input  logic            valid_e,
    input  logic [1:0]      result_src_e,
    input  logic [RA_W-1:0] rd_addr_e,
    input  logic            valid_d,
    input  logic [RA_W-1:0] rs1_addr_d,
    input  logic [RA_W-1:0] rs2_addr_d,
    output logic            lw_stall
);

    // x0 is never a real producer, so a zero destination cannot create a hazard
    assign lw_stall = valid_e && valid_d && (result_src_e == RESULT_LOAD) &&
                      (rd_addr_e != '0) &&
                      ((rd_addr_e == rs1_addr_d) || (rd_addr_e == rs2_addr_d));

endmodule

// File: rtl/decode_execute_reg.sv
// ID/EX pipeline register with built-in load-use bubble insertion.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   dx       : decode inputs in, execute outputs and lw_stall out
// Update priority: reset, bubble (flush or load-use), stall (hold), load.
module decode_execute_reg
    import decode_execute_reg_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input logic                 clk,
    input logic                 rst,
    decode_execute_reg_if.slave dx
);

    typedef struct packed {
        logic            valid;
        ctrl_t           ctrl;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [RA_W-1:0] rs1_addr;
        logic [RA_W-1:0] rs2_addr;
        logic [RA_W-1:0] rd_addr;
    } stage_t;

    stage_t stage_in;
    stage_t stage_d;
    stage_t stage_q;
    logic   lw_hit;
    logic   bubble;

    decode_execute_reg_load_use_detect #(
        .RA_W (RA_W)
    ) u_load_use_detect (
        .valid_e      (stage_q.valid),
        .result_src_e (stage_q.ctrl.result_src),
        .rd_addr_e    (stage_q.rd_addr),
        .valid_d      (dx.valid_d),
        .rs1_addr_d   (dx.rs1_addr_d),
        .rs2_addr_d   (dx.rs2_addr_d),
        .lw_stall     (lw_hit)
    );

    assign dx.lw_stall = lw_hit & ~rst;
    assign bubble      = dx.flush_e | dx.lw_stall;

    always_comb begin
        stage_in                 = '0;
        stage_in.valid           = dx.valid_d;
        stage_in.ctrl.reg_write  = dx.reg_write_d;
        stage_in.ctrl.mem_write  = dx.mem_write_d;
        stage_in.ctrl.result_src = dx.result_src_d;
        stage_in.ctrl.alu_ctrl   = dx.alu_ctrl_d;
        stage_in.ctrl.alu_src    = dx.alu_src_d;
        stage_in.ctrl.branch     = dx.branch_d;
        stage_in.ctrl.jump       = dx.jump_d;
        stage_in.rs1_data        = dx.rs1_data_d;
        stage_in.rs2_data        = dx.rs2_data_d;
        stage_in.imm             = dx.imm_d;
        stage_in.pc              = dx.pc_d;
        stage_in.pc_plus4        = dx.pc_plus4_d;
        stage_in.rs1_addr        = dx.rs1_addr_d;
        stage_in.rs2_addr        = dx.rs2_addr_d;
        stage_in.rd_addr         = dx.rd_addr_d;
    end

    // Bubble outranks stall so a killed or hazarding slot never lingers
    always_comb begin
        stage_d = stage_q;
        if (bubble) begin
            stage_d = '0;
        end else if (!dx.stall_e) begin
            stage_d = stage_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dx.valid_e      = stage_q.valid;
    assign dx.reg_write_e  = stage_q.ctrl.reg_write;
    assign dx.mem_write_e  = stage_q.ctrl.mem_write;
    assign dx.result_src_e = stage_q.ctrl.result_src;
    assign dx.alu_ctrl_e   = stage_q.ctrl.alu_ctrl;
    assign dx.alu_src_e    = stage_q.ctrl.alu_src;
    assign dx.branch_e     = stage_q.ctrl.branch;
    assign dx.jump_e       = stage_q.ctrl.jump;
    assign dx.rs1_data_e   = stage_q.rs1_data;
    assign dx.rs2_data_e   = stage_q.rs2_data;
    assign dx.imm_e        = stage_q.imm;
    assign dx.pc_e         = stage_q.pc;
    assign dx.pc_plus4_e   = stage_q.pc_plus4;
    assign dx.rs1_addr_e   = stage_q.rs1_addr;
    assign dx.rs2_addr_e   = stage_q.rs2_addr;
    assign dx.rd_addr_e    = stage_q.rd_addr;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Scoreboard bench for the ID/EX pipeline register.
module tb_decode_execute_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        reg_write;
        logic        mem_write;
        logic [1:0]  result_src;
        logic [2:0]  alu_ctrl;
        logic        alu_src;
        logic        branch;
        logic        jump;
    } slot_t;

    logic clk;
    logic rst;

    decode_execute_reg_if #(.XLEN(32), .RA_W(5)) dx ();

    decode_execute_reg #(
        .XLEN (32),
        .RA_W (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .dx  (dx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    slot_t exp_q;
    slot_t sb_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_lw(input slot_t e, input slot_t d);
        return e.valid && d.valid && (e.result_src == 2'b01) && (e.rd_addr != 5'd0) &&
               ((e.rd_addr == d.rs1_addr) || (e.rd_addr == d.rs2_addr));
    endfunction

    function automatic slot_t rand_slot();
        slot_t s;
        s.valid      = ($urandom_range(0, 3) != 0);
        s.rs1_data   = $urandom;
        s.rs2_data   = $urandom;
        s.imm        = $urandom;
        s.pc         = $urandom;
        s.pc_plus4   = s.pc + 32'd4;
        s.rs1_addr   = 5'($urandom_range(0, 3));
        s.rs2_addr   = 5'($urandom_range(0, 3));
        s.rd_addr    = 5'($urandom_range(0, 3));
        s.reg_write  = 1'($urandom);
        s.mem_write  = 1'($urandom);
        s.result_src = 2'($urandom_range(0, 2));
        s.alu_ctrl   = 3'($urandom);
        s.alu_src    = 1'($urandom);
        s.branch     = 1'($urandom);
        s.jump       = 1'($urandom);
        return s;
    endfunction

    task automatic apply(input slot_t s, input logic flush, input logic stall);
        dx.valid_d      = s.valid;
        dx.rs1_data_d   = s.rs1_data;
        dx.rs2_data_d   = s.rs2_data;
        dx.imm_d        = s.imm;
        dx.pc_d         = s.pc;
        dx.pc_plus4_d   = s.pc_plus4;
        dx.rs1_addr_d   = s.rs1_addr;
        dx.rs2_addr_d   = s.rs2_addr;
        dx.rd_addr_d    = s.rd_addr;
        dx.reg_write_d  = s.reg_write;
        dx.mem_write_d  = s.mem_write;
        dx.result_src_d = s.result_src;
        dx.alu_ctrl_d   = s.alu_ctrl;
        dx.alu_src_d    = s.alu_src;
        dx.branch_d     = s.branch;
        dx.jump_d       = s.jump;
        dx.flush_e      = flush;
        dx.stall_e      = stall;
    endtask

    task automatic check_outputs(input string pfx, input slot_t e);
        check({pfx, ".valid_e"},      64'(dx.valid_e),      64'(e.valid));
        check({pfx, ".rs1_data_e"},   64'(dx.rs1_data_e),   64'(e.rs1_data));
        check({pfx, ".rs2_data_e"},   64'(dx.rs2_data_e),   64'(e.rs2_data));
        check({pfx, ".imm_e"},        64'(dx.imm_e),        64'(e.imm));
        check({pfx, ".pc_e"},         64'(dx.pc_e),         64'(e.pc));
        check({pfx, ".pc_plus4_e"},   64'(dx.pc_plus4_e),   64'(e.pc_plus4));
        check({pfx, ".rs1_addr_e"},   64'(dx.rs1_addr_e),   64'(e.rs1_addr));
        check({pfx, ".rs2_addr_e"},   64'(dx.rs2_addr_e),   64'(e.rs2_addr));
        check({pfx, ".rd_addr_e"},    64'(dx.rd_addr_e),    64'(e.rd_addr));
        check({pfx, ".reg_write_e"},  64'(dx.reg_write_e),  64'(e.reg_write));
        check({pfx, ".mem_write_e"},  64'(dx.mem_write_e),  64'(e.mem_write));
        check({pfx, ".result_src_e"}, 64'(dx.result_src_e), 64'(e.result_src));
        check({pfx, ".alu_ctrl_e"},   64'(dx.alu_ctrl_e),   64'(e.alu_ctrl));
        check({pfx, ".alu_src_e"},    64'(dx.alu_src_e),    64'(e.alu_src));
        check({pfx, ".branch_e"},     64'(dx.branch_e),     64'(e.branch));
        check({pfx, ".jump_e"},       64'(dx.jump_e),       64'(e.jump));
    endtask

    // Drive one decode slot, check lw_stall, predict the next register
    // contents, then compare after the edge.
    task automatic step(input string tag, input slot_t s, input logic flush,
                        input logic stall);
        logic  lw;
        slot_t nxt;
        slot_t got;
        apply(s, flush, stall);
        #1;
        lw = model_lw(exp_q, s);
        check({tag, ".lw_stall"}, 64'(dx.lw_stall), 64'(lw));
        if (flush || lw) nxt = '0;
        else if (stall)  nxt = exp_q;
        else             nxt = s;
        sb_q.push_back(nxt);
        exp_q = nxt;
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_outputs(tag, got);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        slot_t s;
        exp_q = '0;
        rst   = 1'b1;
        apply('0, 1'b0, 1'b0);
        #2;
        check_outputs("reset", '0);
        check("reset.lw_stall", 64'(dx.lw_stall), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Normal load
        s = '0;
        s.valid = 1'b1; s.rs1_data = 32'h1234_5678; s.rd_addr = 5'd5;
        s.reg_write = 1'b1; s.alu_ctrl = 3'b010;
        step("normal", s, 1'b0, 1'b0);
        check("normal.rs1", 64'(dx.rs1_data_e), 64'h1234_5678);

        // Asynchronous reset while a writing instruction is held
        #2;
        rst = 1'b1;
        #1;
        check_outputs("async_rst", '0);
        check("async_rst.lw_stall", 64'(dx.lw_stall), 64'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        exp_q = '0;

        // Load-use: load to x7 followed by a reader of x7
        s = '0;
        s.valid = 1'b1; s.rd_addr = 5'd7; s.reg_write = 1'b1; s.result_src = 2'b01;
        step("lu_load", s, 1'b0, 1'b0);
        s = '0;
        s.valid = 1'b1; s.rs2_addr = 5'd7; s.rd_addr = 5'd9; s.reg_write = 1'b1;
        apply(s, 1'b0, 1'b0);
        #1;
        check("lu_hit", 64'(dx.lw_stall), 64'd1);
        step("lu_use", s, 1'b0, 1'b0);
        check("lu_bubble_valid", 64'(dx.valid_e), 64'd0);

        // Same pattern with a load to x0 never stalls
        s = '0;
        s.valid = 1'b1; s.rd_addr = 5'd0; s.reg_write = 1'b1; s.result_src = 2'b01;
        step("lu0_load", s, 1'b0, 1'b0);
        s = '0;
        s.valid = 1'b1; s.rs2_addr = 5'd0; s.rs1_addr = 5'd0; s.rd_addr = 5'd2;
        apply(s, 1'b0, 1'b0);
        #1;
        check("lu0_nohit", 64'(dx.lw_stall), 64'd0);
        step("lu0_use", s, 1'b0, 1'b0);

        // Flush together with stall loads a bubble
        s = rand_slot();
        s.valid = 1'b1; s.mem_write = 1'b1; s.jump = 1'b1; s.result_src = 2'b00;
        step("fs_pre", s, 1'b0, 1'b0);
        step("flush_stall", rand_slot(), 1'b1, 1'b1);

        // Stall hold over three edges with changing inputs
        s = rand_slot();
        s.valid = 1'b1; s.pc = 32'h0000_0040; s.result_src = 2'b00;
        step("hold_load", s, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("hold", rand_slot(), 1'b0, 1'b1);
            check("hold.pc", 64'(dx.pc_e), 64'h40);
        end

        // Back-to-back: load to x3, then independent ALU op on x4/x5
        s = '0;
        s.valid = 1'b1; s.rd_addr = 5'd3; s.result_src = 2'b01; s.reg_write = 1'b1;
        step("b2b_load", s, 1'b0, 1'b0);
        s = rand_slot();
        s.valid = 1'b1; s.rs1_addr = 5'd4; s.rs2_addr = 5'd5; s.result_src = 2'b00;
        step("b2b_alu", s, 1'b0, 1'b0);

        // Random mix
        for (int i = 0; i < 60; i++) begin
            step("rand", rand_slot(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
